// File: rtl/data_memory_timers.sv
// Data memory for the MEM stage: word-addressed RAM plus a peripheral window
// holding TIMER_CH prescaled timers, LED/digit registers, systick and IRQ status.
module data_memory_timers #(
    parameter int RAM_WORDS = 256,
    parameter int TIMER_CH  = 2,
    parameter int LED_W     = 8,
    parameter int DIGI_W    = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       Address,
    input  logic [31:0]       Write_data,
    input  logic              MemRead,
    input  logic              MemWrite,
    output logic [31:0]       Read_data,
    output logic              Interrupt,
    output logic [LED_W-1:0]  led_out,
    output logic [DIGI_W-1:0] digi_out
);

    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0]         ram [RAM_WORDS];
    logic [31:0]         th [TIMER_CH];
    logic [31:0]         tl [TIMER_CH];
    logic [15:0]         presc [TIMER_CH];
    logic [15:0]         pcnt [TIMER_CH];
    logic [TIMER_CH-1:0] en, irq_en, pend, one_shot;
    logic [LED_W-1:0]    led;
    logic [DIGI_W-1:0]   digi;
    logic [31:0]         systick;

    logic                in_win;
    logic [7:0]          offs;
    logic [1:0]          ch_sel;
    logic [1:0]          reg_sel;
    logic                ch_hit;
    logic [AW-1:0]       ram_idx;
    logic                wr_stat;
    logic                unused_offs;

    assign in_win      = (Address[31:8] == 24'h40_0000);
    assign offs        = Address[7:0];
    assign ch_sel      = offs[5:4];
    assign reg_sel     = offs[3:2];
    assign ch_hit      = in_win && (offs[7:6] == 2'b00) && (int'(ch_sel) < TIMER_CH);
    assign ram_idx     = Address[AW+1:2];
    assign wr_stat     = MemWrite && in_win && (offs[7:2] == 6'h23);
    assign unused_offs = ^offs[1:0];

    logic [TIMER_CH-1:0] sel, wr_th, wr_tl, wr_tcon, wr_presc, tick, ovf, clr;

    // A TL write in a tick cycle swallows the tick, so it can neither increment nor overflow.
    always_comb begin
        sel      = '0;
        wr_th    = '0;
        wr_tl    = '0;
        wr_tcon  = '0;
        wr_presc = '0;
        tick     = '0;
        ovf      = '0;
        clr      = '0;
        for (int n = 0; n < TIMER_CH; n++) begin
            sel[n]      = ch_hit && (ch_sel == 2'(n));
            wr_th[n]    = MemWrite && sel[n] && (reg_sel == 2'd0);
            wr_tl[n]    = MemWrite && sel[n] && (reg_sel == 2'd1);
            wr_tcon[n]  = MemWrite && sel[n] && (reg_sel == 2'd2);
            wr_presc[n] = MemWrite && sel[n] && (reg_sel == 2'd3);
            tick[n]     = en[n] && (pcnt[n] == presc[n]);
            ovf[n]      = tick[n] && !wr_tl[n] && (tl[n] == 32'hFFFF_FFFF);
            clr[n]      = (wr_tcon[n] && Write_data[2]) || (wr_stat && Write_data[n]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < TIMER_CH; n++) begin
                th[n]    <= '0;
                tl[n]    <= '0;
                presc[n] <= '0;
                pcnt[n]  <= '0;
            end
            en       <= '0;
            irq_en   <= '0;
            pend     <= '0;
            one_shot <= '0;
        end else begin
            for (int n = 0; n < TIMER_CH; n++) begin
                if (wr_th[n]) th[n] <= Write_data;

                if (wr_tl[n])      tl[n] <= Write_data;
                else if (ovf[n])   tl[n] <= th[n];
                else if (tick[n])  tl[n] <= tl[n] + 32'd1;

                if (wr_presc[n]) presc[n] <= Write_data[15:0];

                if (wr_tcon[n]) begin
                    en[n]       <= Write_data[0];
                    irq_en[n]   <= Write_data[1];
                    one_shot[n] <= Write_data[3];
                end else if (ovf[n] && one_shot[n]) begin
                    en[n] <= 1'b0;
                end

                // Overflow beats a same-cycle software clear.
                if (ovf[n] && irq_en[n]) pend[n] <= 1'b1;
                else if (clr[n])         pend[n] <= 1'b0;

                if (wr_presc[n] || (wr_tcon[n] && !Write_data[0])) pcnt[n] <= '0;
                else if (tick[n])                                  pcnt[n] <= '0;
                else if (en[n])                                    pcnt[n] <= pcnt[n] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led     <= '0;
            digi    <= '1;
            systick <= '0;
        end else begin
            systick <= systick + 32'd1;
            if (MemWrite && in_win && (offs[7:2] == 6'h20)) led  <= Write_data[LED_W-1:0];
            if (MemWrite && in_win && (offs[7:2] == 6'h21)) digi <= Write_data[DIGI_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RAM_WORDS; i++) ram[i] <= '0;
        end else if (MemWrite && !in_win) begin
            ram[ram_idx] <= Write_data;
        end
    end

    always_comb begin
        Read_data = '0;
        if (MemRead) begin
            if (!in_win) begin
                Read_data = ram[ram_idx];
            end else if (ch_hit) begin
                for (int n = 0; n < TIMER_CH; n++) begin
                    if (sel[n]) begin
                        case (reg_sel)
                            2'd0:    Read_data = th[n];
                            2'd1:    Read_data = tl[n];
                            2'd2:    Read_data = {28'b0, one_shot[n], pend[n], irq_en[n], en[n]};
                            default: Read_data = {16'b0, presc[n]};
                        endcase
                    end
                end
            end else begin
                case (offs[7:2])
                    6'h20:   Read_data = 32'(led);
                    6'h21:   Read_data = 32'(digi);
                    6'h22:   Read_data = systick;
                    6'h23:   Read_data = 32'(pend);
                    default: Read_data = '0;
                endcase
            end
        end
    end

    assign Interrupt = |(pend & irq_en);
    assign led_out   = led;
    assign digi_out  = digi;

endmodule

// File: tb/tb_data_memory_timers.sv
// Bench for data_memory_timers: directed scenarios plus random bus traffic,
// checked every cycle against a transaction-level model of the memory map.
`timescale 1ns/1ps
module tb_data_memory_timers;
    localparam int RAM_WORDS = 256;
    localparam int TIMER_CH  = 2;
    localparam int LED_W     = 8;
    localparam int DIGI_W    = 12;

    localparam logic [31:0] TH0 = 32'h4000_0000, TL0 = 32'h4000_0004;
    localparam logic [31:0] TC0 = 32'h4000_0008, PR0 = 32'h4000_000C;
    localparam logic [31:0] TH1 = 32'h4000_0010, TL1 = 32'h4000_0014;
    localparam logic [31:0] TC1 = 32'h4000_0018, PR1 = 32'h4000_001C;
    localparam logic [31:0] LED = 32'h4000_0080, DIGI = 32'h4000_0084;
    localparam logic [31:0] STK = 32'h4000_0088, ISTAT = 32'h4000_008C;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [31:0]       Address = '0;
    logic [31:0]       Write_data = '0;
    logic              MemRead = 1'b0;
    logic              MemWrite = 1'b0;
    logic [31:0]       Read_data;
    logic              Interrupt;
    logic [LED_W-1:0]  led_out;
    logic [DIGI_W-1:0] digi_out;

    data_memory_timers #(
        .RAM_WORDS(RAM_WORDS), .TIMER_CH(TIMER_CH), .LED_W(LED_W), .DIGI_W(DIGI_W)
    ) dut (
        .clk(clk), .reset(reset), .Address(Address), .Write_data(Write_data),
        .MemRead(MemRead), .MemWrite(MemWrite), .Read_data(Read_data),
        .Interrupt(Interrupt), .led_out(led_out), .digi_out(digi_out)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state. Prescaler is modelled as "cycles left until the next tick".
    logic [31:0]       m_ram [RAM_WORDS];
    logic [31:0]       m_th [TIMER_CH];
    logic [31:0]       m_tl [TIMER_CH];
    logic [15:0]       m_presc [TIMER_CH];
    logic [15:0]       m_wait [TIMER_CH];
    bit                m_en [TIMER_CH];
    bit                m_irq [TIMER_CH];
    bit                m_pend [TIMER_CH];
    bit                m_os [TIMER_CH];
    logic [LED_W-1:0]  m_led;
    logic [DIGI_W-1:0] m_digi;
    logic [31:0]       m_systick;

    function automatic void model_reset();
        for (int i = 0; i < RAM_WORDS; i++) m_ram[i] = '0;
        for (int n = 0; n < TIMER_CH; n++) begin
            m_th[n] = '0; m_tl[n] = '0; m_presc[n] = '0; m_wait[n] = '0;
            m_en[n] = 0; m_irq[n] = 0; m_pend[n] = 0; m_os[n] = 0;
        end
        m_led = '0;
        m_digi = '1;
        m_systick = '0;
    endfunction

    function automatic bit model_irq();
        bit r;
        r = 0;
        for (int n = 0; n < TIMER_CH; n++) r = r | (m_pend[n] & m_irq[n]);
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] r;
        int w;
        r = '0;
        w = int'(a[7:2]);
        if (a[31:8] != 24'h40_0000) return m_ram[a[9:2]];
        if (w < 4 * TIMER_CH) begin
            case (w % 4)
                0: r = m_th[w / 4];
                1: r = m_tl[w / 4];
                2: r = {28'b0, m_os[w / 4], m_pend[w / 4], m_irq[w / 4], m_en[w / 4]};
                default: r = {16'b0, m_presc[w / 4]};
            endcase
        end else if (w == 32) r = 32'(m_led);
        else if (w == 33) r = 32'(m_digi);
        else if (w == 34) r = m_systick;
        else if (w == 35) for (int n = 0; n < TIMER_CH; n++) r[n] = m_pend[n];
        return r;
    endfunction

    function automatic void model_step(input logic [31:0] a, input logic [31:0] d, input bit wr);
        bit in_win;
        int w;
        in_win = (a[31:8] == 24'h40_0000);
        w = int'(a[7:2]);
        for (int n = 0; n < TIMER_CH; n++) begin
            bit hit, tck, w_tl, w_tc, w_pr, of, clear;
            hit   = wr && in_win && (w / 4 == n) && (w < 4 * TIMER_CH);
            w_tl  = hit && (w % 4 == 1);
            w_tc  = hit && (w % 4 == 2);
            w_pr  = hit && (w % 4 == 3);
            tck   = m_en[n] && (m_wait[n] == 0);
            of    = tck && !w_tl && (m_tl[n] == 32'hFFFF_FFFF);
            clear = (w_tc && d[2]) || (wr && in_win && w == 35 && d[n]);
            if (of && m_irq[n]) m_pend[n] = 1;
            else if (clear)     m_pend[n] = 0;
            if (w_tl)      m_tl[n] = d;
            else if (of)   m_tl[n] = m_th[n];
            else if (tck)  m_tl[n] = m_tl[n] + 1;
            if (hit && (w % 4 == 0)) m_th[n] = d;
            if (w_pr) m_presc[n] = d[15:0];
            if (w_pr || (w_tc && !d[0]) || tck) m_wait[n] = m_presc[n];
            else if (m_en[n])                   m_wait[n] = m_wait[n] - 1;
            if (w_tc) begin
                m_en[n] = d[0]; m_irq[n] = d[1]; m_os[n] = d[3];
            end else if (of && m_os[n]) begin
                m_en[n] = 0;
            end
        end
        if (wr && in_win && w == 32) m_led = d[LED_W-1:0];
        if (wr && in_win && w == 33) m_digi = d[DIGI_W-1:0];
        if (wr && !in_win) m_ram[a[9:2]] = d;
        m_systick = m_systick + 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive at negedge, compare, then advance the model at posedge.
    task automatic cycle(input logic [31:0] a, input logic [31:0] d, input bit rd, input bit wr,
                         output logic [31:0] rdv, output logic irqv);
        @(negedge clk);
        Address = a; Write_data = d; MemRead = rd; MemWrite = wr;
        #1;
        rdv = Read_data;
        irqv = Interrupt;
        check("read_data", Read_data, rd ? model_read(a) : 32'h0);
        check("interrupt", {31'b0, Interrupt}, {31'b0, model_irq()});
        check("led_out", 32'(led_out), 32'(m_led));
        check("digi_out", 32'(digi_out), 32'(m_digi));
        @(posedge clk);
        model_step(a, d, wr);
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] v;
        logic i;
        cycle(a, d, 1'b0, 1'b1, v, i);
    endtask

    task automatic rd_reg(input logic [31:0] a, output logic [31:0] v, output logic i);
        cycle(a, 32'h0, 1'b1, 1'b0, v, i);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
    endtask

    initial begin
        logic [31:0] v;
        logic        irq;
        logic [31:0] a, d;
        int          w;

        model_reset();
        release_reset();

        // Reset values
        rd_reg(STK, v, irq);  check("systick_first", v, 32'h0);
        rd_reg(DIGI, v, irq); check("digi_reset", v, 32'h0000_0FFF);
        rd_reg(LED, v, irq);  check("led_reset", v, 32'h0);
        rd_reg(TH0, v, irq);  check("th_reset", v, 32'h0);
        rd_reg(TL0, v, irq);  check("tl_reset", v, 32'h0);
        rd_reg(TC0, v, irq);  check("tcon_reset", v, 32'h0);
        cycle(DIGI, 32'h0, 1'b0, 1'b0, v, irq); check("no_memread", v, 32'h0);

        // Channel 0 auto-reload
        wr_reg(TH0, 32'hFFFF_FFFD);
        wr_reg(TL0, 32'hFFFF_FFFE);
        wr_reg(PR0, 32'h0);
        wr_reg(TC0, 32'h3);
        rd_reg(TL0, v, irq); check("ar_tl_a", v, 32'hFFFF_FFFE); check("ar_irq_a", {31'b0, irq}, 32'h0);
        rd_reg(TL0, v, irq); check("ar_tl_b", v, 32'hFFFF_FFFF); check("ar_irq_b", {31'b0, irq}, 32'h0);
        rd_reg(TL0, v, irq); check("ar_tl_c", v, 32'hFFFF_FFFD); check("ar_irq_c", {31'b0, irq}, 32'h1);
        rd_reg(TL0, v, irq); check("ar_irq_hold1", {31'b0, irq}, 32'h1);
        rd_reg(TL0, v, irq); check("ar_irq_hold2", {31'b0, irq}, 32'h1);
        wr_reg(TC0, 32'h7);
        rd_reg(TL0, v, irq); check("ar_irq_clr", {31'b0, irq}, 32'h0); check("ar_running", v, 32'hFFFF_FFFE);
        wr_reg(TC0, 32'h4);

        // Channel 1 one-shot with prescaler
        wr_reg(TH1, 32'h0000_1234);
        wr_reg(PR1, 32'h3);
        wr_reg(TL1, 32'hFFFF_FFFF);
        wr_reg(TC1, 32'hB);
        for (int k = 0; k < 4; k++) begin
            rd_reg(TL1, v, irq); check("os_wait", v, 32'hFFFF_FFFF);
        end
        rd_reg(TC1, v, irq); check("os_tcon", v, 32'hE); check("os_irq", {31'b0, irq}, 32'h1);
        rd_reg(TL1, v, irq); check("os_reload", v, 32'h0000_1234);
        repeat (6) rd_reg(TL1, v, irq);
        check("os_frozen", v, 32'h0000_1234);
        wr_reg(ISTAT, 32'h2);
        rd_reg(TC1, v, irq); check("os_cleared", v, 32'hA); check("os_irq_low", {31'b0, irq}, 32'h0);

        // Simultaneous events
        wr_reg(TH0, 32'h0000_0100);
        wr_reg(PR0, 32'h0);
        wr_reg(TL0, 32'hFFFF_FFFF);
        wr_reg(TC0, 32'h3);
        wr_reg(ISTAT, 32'h1);
        rd_reg(ISTAT, v, irq); check("set_beats_clear", v, 32'h1); check("sim_irq", {31'b0, irq}, 32'h1);
        wr_reg(TL0, 32'h10);
        rd_reg(TL0, v, irq); check("tl_write_wins", v, 32'h10);
        rd_reg(TL0, v, irq); check("tl_after_write", v, 32'h11);
        wr_reg(TC0, 32'h4);

        // RAM aliasing and unmapped window
        wr_reg(32'h0000_0404, 32'hDEAD_BEEF);
        rd_reg(32'h0000_0004, v, irq); check("ram_alias", v, 32'hDEAD_BEEF);
        wr_reg(32'h4000_00F0, 32'h55);
        rd_reg(32'h4000_00F0, v, irq); check("unmapped_f0", v, 32'h0);
        wr_reg(32'h4000_0020, 32'h77);
        rd_reg(32'h4000_0020, v, irq); check("unmapped_ch2", v, 32'h0);
        wr_reg(LED, 32'hA5);
        wr_reg(DIGI, 32'h123);

        // Random traffic against the model
        for (int k = 0; k < 1500; k++) begin
            if (($urandom_range(0, 9)) < 6) begin
                if ($urandom_range(0, 3) == 0) w = 32 + int'($urandom_range(0, 3));
                else if ($urandom_range(0, 7) == 0) w = int'($urandom_range(0, 63));
                else w = int'($urandom_range(0, 11));
                a = 32'h4000_0000 | (32'(w) << 2) | 32'($urandom_range(0, 3));
            end else begin
                a = $urandom;
                if (a[31:8] == 24'h40_0000) a[31] = 1'b1;
            end
            d = $urandom;
            if (a[31:8] == 24'h40_0000 && w < 12) begin
                if (w % 4 == 1 || w % 4 == 0)
                    if ($urandom_range(0, 1) == 1) d = 32'hFFFF_FFFF - $urandom_range(0, 6);
                if (w % 4 == 3) d = $urandom_range(0, 3);
                if (w % 4 == 2 && $urandom_range(0, 2) != 0) d[0] = 1'b1;
            end
            cycle(a, d, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, v, irq);
        end

        // Async reset while an interrupt is pending
        wr_reg(TC0, 32'h4);
        wr_reg(PR0, 32'h0);
        wr_reg(TL0, 32'hFFFF_FFFF);
        wr_reg(TC0, 32'h3);
        rd_reg(TL0, v, irq);
        rd_reg(TL0, v, irq); check("pre_reset_irq", {31'b0, irq}, 32'h1);
        @(negedge clk);
        #1 reset = 1'b0;
        model_reset();
        MemWrite = 1'b0; MemRead = 1'b1; Address = TL0;
        #1 check("async_irq", {31'b0, Interrupt}, 32'h0);
        check("async_tl0", Read_data, 32'h0);
        Address = TC0;
        #1 check("async_tcon0", Read_data, 32'h0);
        Address = TH0;
        #1 check("async_th0", Read_data, 32'h0);
        Address = TL1;
        #1 check("async_tl1", Read_data, 32'h0);
        release_reset();
        rd_reg(STK, v, irq);  check("systick_after_reset", v, 32'h0);
        rd_reg(DIGI, v, irq); check("digi_after_reset", v, 32'h0000_0FFF);
        rd_reg(32'h0000_0004, v, irq); check("ram_after_reset", v, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
